display_update_arbiter: RTL and testbench
=========================================

DISPLAY_UPDATE_ARBITER -- requirements
Module: display_update_arbiter

Interface
REQ-001 SHALL have parameter: PAGE_FRAMES, 120, frames per page toggle (legal 1..255).
REQ-002 SHALL have port: iclock  in  1  system clock (VGA pixel clock).
REQ-003 SHALL have port: ireset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: iframe_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-005 SHALL have port: itemp_req  in  1  temperature source update request.
REQ-006 SHALL have port: itemp_data  in  8  temperature value.
REQ-007 SHALL have port: itemp_dig  in  4  temperature digit enables.
REQ-008 SHALL have port: otemp_ack  out  1  temperature capture acknowledge.
REQ-009 SHALL have port: imus_req  in  1  music source update request.
REQ-010 SHALL have port: imus_autor  in  16  author text code.
REQ-011 SHALL have port: imus_musica  in  16  track text code.
REQ-012 SHALL have port: imus_atual  in  1  current-track flag.
REQ-013 SHALL have port: omus_ack  out  1  music capture acknowledge.
REQ-014 SHALL have ports: otemperatura 8, odig_temp 4, oautor 16, omusica 16, omusica_atual 1; all out; committed values feeding the VGA pixel generator.
REQ-015 SHALL have ports: ocommit  out  1  one-cycle commit pulse; opending  out  1  OR of pending flags; opage  out  1  display page select.

Function
REQ-016 FSM states: IDLE, ACK_T, ACK_M; all outputs registered.
REQ-017 In IDLE, an edge sampling a request SHALL load that source's data into its staging registers, set its pending flag, and enter ACK_T/ACK_M.
REQ-018 Ack SHALL be high exactly the one cycle the FSM is in ACK_T/ACK_M; the next edge returns to IDLE; latency req-sampled to ack = 1 cycle.
REQ-019 Requests SHALL be sampled only in IDLE; a req still high in IDLE after ack is a new request (re-capture).
REQ-020 Both requests high in IDLE: grant the source not granted last (round-robin); after reset temperature wins first.
REQ-021 On an edge with iframe_start=1: outputs of each source with pending=1 SHALL take its staging values (pre-edge), pending flags clear, ocommit=1 for one cycle; sources with pending=0 keep outputs unchanged.
REQ-022 iframe_start with no pending flag SHALL still pulse ocommit and leave outputs unchanged.
REQ-023 Capture and iframe_start on the same edge: commit uses pre-edge staging; the captured source's pending stays 1 and commits at the next frame.
REQ-024 opending SHALL reflect pending flags in the same cycle they change (registered OR).

Reset
REQ-025 ireset=1 at an edge SHALL force IDLE, acks 0, pending 0, staging 0, otemperatura 0, odig_temp 0, oautor 0, omusica 0, omusica_atual 0, ocommit 0, opage 0, frame counter 0, round-robin pointer to favour temperature; overrides every concurrent event, including mid-ACK.

Configuration
REQ-026 Macro PAGE_ROTATE_EN defined: frame counter counts iframe_start pulses 0..PAGE_FRAMES-1; the pulse at count PAGE_FRAMES-1 wraps it to 0 and toggles opage on the same edge as any commit.
REQ-027 PAGE_ROTATE_EN undefined: no frame counter is built and opage is constant 0.

Verification
REQ-028 Reset then single itemp_req, itemp_data=8'h1A, itemp_dig=4'b0011 -> otemp_ack high exactly 1 cycle after sample; otemperatura stays 0 until the next iframe_start, then 8'h1A with odig_temp=4'b0011 and ocommit=1.
REQ-029 Both reqs held high 6 cycles -> acks alternate T,M,T (one per 2 cycles), temperature first; both pending; one iframe_start commits both.
REQ-030 imus_req captured on the same edge as iframe_start with prior staging autor=16'h0001, new 16'h0002 -> oautor=16'h0001 now, opending stays 1, next frame oautor=16'h0002.
REQ-031 ireset asserted during ACK_M -> omus_ack 0 next cycle, all outputs 0, no commit at following iframe_start.
REQ-032 PAGE_ROTATE_EN, PAGE_FRAMES=3, 7 iframe_start pulses -> opage toggles after pulses 3 and 6 (1 then 0); undefined -> opage stays 0.

Source files
------------

// File: rtl/display_update_arbiter.sv
// display_update_arbiter: round-robin capture of temperature/music updates, committed to the display on frame start.
// Optional page rotation every PAGE_FRAMES frames is built when PAGE_ROTATE_EN is defined.
module display_update_arbiter #(
    parameter int PAGE_FRAMES = 120
) (
    input  logic        iclock,
    input  logic        ireset,
    input  logic        iframe_start,
    input  logic        itemp_req,
    input  logic [7:0]  itemp_data,
    input  logic [3:0]  itemp_dig,
    output logic        otemp_ack,
    input  logic        imus_req,
    input  logic [15:0] imus_autor,
    input  logic [15:0] imus_musica,
    input  logic        imus_atual,
    output logic        omus_ack,
    output logic [7:0]  otemperatura,
    output logic [3:0]  odig_temp,
    output logic [15:0] oautor,
    output logic [15:0] omusica,
    output logic        omusica_atual,
    output logic        ocommit,
    output logic        opending,
    output logic        opage
);
    typedef enum logic [1:0] {IDLE, ACK_T, ACK_M} state_t;
    state_t state, next_state;
    logic prefer_t, grant_t, grant_m, pend_t, pend_m, pend_t_n, pend_m_n;
    logic [7:0]  st_temp;
    logic [3:0]  st_dig;
    logic [15:0] st_autor, st_musica;
    logic        st_atual;
    always_comb begin
        grant_t = 1'b0;
        grant_m = 1'b0;
        next_state = IDLE;
        if (state == IDLE) begin
            grant_t = itemp_req & (~imus_req | prefer_t);
            grant_m = imus_req & ~grant_t;
            next_state = grant_t ? ACK_T : grant_m ? ACK_M : IDLE;
        end
        // a capture on a commit edge keeps its pending flag for the next frame
        pend_t_n = grant_t | (pend_t & ~iframe_start);
        pend_m_n = grant_m | (pend_m & ~iframe_start);
    end
    always_ff @(posedge iclock) begin
        if (ireset) begin
            state <= IDLE;
            prefer_t <= 1'b1;
            otemp_ack <= 1'b0;
            omus_ack <= 1'b0;
            pend_t <= 1'b0;
            pend_m <= 1'b0;
            opending <= 1'b0;
            ocommit <= 1'b0;
            st_temp <= '0;
            st_dig <= '0;
            st_autor <= '0;
            st_musica <= '0;
            st_atual <= 1'b0;
            otemperatura <= '0;
            odig_temp <= '0;
            oautor <= '0;
            omusica <= '0;
            omusica_atual <= 1'b0;
        end else begin
            state <= next_state;
            otemp_ack <= next_state == ACK_T;
            omus_ack <= next_state == ACK_M;
            if (grant_t) prefer_t <= 1'b0;
            if (grant_m) prefer_t <= 1'b1;
            pend_t <= pend_t_n;
            pend_m <= pend_m_n;
            opending <= pend_t_n | pend_m_n;
            ocommit <= iframe_start;
            if (iframe_start && pend_t) begin
                otemperatura <= st_temp;
                odig_temp <= st_dig;
            end
            if (iframe_start && pend_m) begin
                oautor <= st_autor;
                omusica <= st_musica;
                omusica_atual <= st_atual;
            end
            if (grant_t) begin
                st_temp <= itemp_data;
                st_dig <= itemp_dig;
            end
            if (grant_m) begin
                st_autor <= imus_autor;
                st_musica <= imus_musica;
                st_atual <= imus_atual;
            end
        end
    end
`ifdef PAGE_ROTATE_EN
    logic [7:0] frame_cnt;
    always_ff @(posedge iclock) begin
        if (ireset) begin
            frame_cnt <= '0;
            opage <= 1'b0;
        end else if (iframe_start) begin
            frame_cnt <= (frame_cnt == 8'(PAGE_FRAMES - 1)) ? 8'd0 : frame_cnt + 8'd1;
            if (frame_cnt == 8'(PAGE_FRAMES - 1)) opage <= ~opage;
        end
    end
`else
    assign opage = 1'b0;
`endif
endmodule

// File: tb/tb_display_update_arbiter.sv
// tb_display_update_arbiter: directed checks of capture, round-robin, commit, reset and page rotation.
module tb_display_update_arbiter;
    logic        iclock = 1'b0;
    logic        ireset = 1'b1;
    logic        iframe_start = 1'b0;
    logic        itemp_req = 1'b0;
    logic [7:0]  itemp_data = '0;
    logic [3:0]  itemp_dig = '0;
    logic        otemp_ack;
    logic        imus_req = 1'b0;
    logic [15:0] imus_autor = '0;
    logic [15:0] imus_musica = '0;
    logic        imus_atual = 1'b0;
    logic        omus_ack;
    logic [7:0]  otemperatura;
    logic [3:0]  odig_temp;
    logic [15:0] oautor;
    logic [15:0] omusica;
    logic        omusica_atual;
    logic        ocommit;
    logic        opending;
    logic        opage;
    int checks = 0;
    int failures = 0;

    display_update_arbiter #(.PAGE_FRAMES(3)) dut (
        .iclock(iclock), .ireset(ireset), .iframe_start(iframe_start),
        .itemp_req(itemp_req), .itemp_data(itemp_data), .itemp_dig(itemp_dig), .otemp_ack(otemp_ack),
        .imus_req(imus_req), .imus_autor(imus_autor), .imus_musica(imus_musica), .imus_atual(imus_atual),
        .omus_ack(omus_ack), .otemperatura(otemperatura), .odig_temp(odig_temp), .oautor(oautor),
        .omusica(omusica), .omusica_atual(omusica_atual), .ocommit(ocommit), .opending(opending),
        .opage(opage)
    );

    always #5 iclock = ~iclock;

    task automatic tick();
        @(posedge iclock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_temp"}, 32'(otemperatura), 0);
        chk({tag, "_dig"}, 32'(odig_temp), 0);
        chk({tag, "_autor"}, 32'(oautor), 0);
        chk({tag, "_musica"}, 32'(omusica), 0);
        chk({tag, "_atual"}, 32'(omusica_atual), 0);
        chk({tag, "_pend"}, 32'(opending), 0);
        chk({tag, "_acks"}, 32'({otemp_ack, omus_ack}), 0);
        chk({tag, "_page"}, 32'(opage), 0);
    endtask

    initial begin
        logic [1:0] ack_exp [6];
        ack_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        tick();
        tick();
        chk_all_zero("reset");
        chk("reset_commit", 32'(ocommit), 0);
        ireset = 1'b0;

        // single temperature update
        itemp_req = 1'b1; itemp_data = 8'h1A; itemp_dig = 4'b0011;
        tick();
        chk("t1_ack", 32'(otemp_ack), 1);
        chk("t1_pend", 32'(opending), 1);
        chk("t1_temp_held", 32'(otemperatura), 0);
        itemp_req = 1'b0;
        tick();
        chk("t1_ack_drop", 32'(otemp_ack), 0);
        tick();
        chk("t1_temp_wait", 32'(otemperatura), 0);
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        chk("t1_commit", 32'(ocommit), 1);
        chk("t1_temp", 32'(otemperatura), 32'h1A);
        chk("t1_dig", 32'(odig_temp), 32'h3);
        chk("t1_pend_clr", 32'(opending), 0);
        tick();
        chk("t1_commit_pulse", 32'(ocommit), 0);

        // round-robin with both requests held
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        itemp_req = 1'b1; itemp_data = 8'h22; itemp_dig = 4'b0101;
        imus_req = 1'b1; imus_autor = 16'hA1A1; imus_musica = 16'hB2B2; imus_atual = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_acks_%0d", i), 32'({otemp_ack, omus_ack}), 32'(ack_exp[i]));
        end
        itemp_req = 1'b0; imus_req = 1'b0;
        chk("rr_pend", 32'(opending), 1);
        chk("rr_autor_held", 32'(oautor), 0);
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        chk("rr_temp", 32'(otemperatura), 32'h22);
        chk("rr_dig", 32'(odig_temp), 32'h5);
        chk("rr_autor", 32'(oautor), 32'hA1A1);
        chk("rr_musica", 32'(omusica), 32'hB2B2);
        chk("rr_atual", 32'(omusica_atual), 1);
        chk("rr_pend_clr", 32'(opending), 0);

        // empty commit leaves outputs alone
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        chk("empty_commit", 32'(ocommit), 1);
        chk("empty_autor", 32'(oautor), 32'hA1A1);

        // capture coinciding with frame start
        imus_req = 1'b1; imus_autor = 16'h0001;
        tick();
        imus_req = 1'b0;
        tick();
        imus_req = 1'b1; imus_autor = 16'h0002; iframe_start = 1'b1;
        tick();
        imus_req = 1'b0; iframe_start = 1'b0;
        chk("co_autor_old", 32'(oautor), 32'h0001);
        chk("co_ack", 32'(omus_ack), 1);
        chk("co_pend", 32'(opending), 1);
        tick();
        chk("co_pend_hold", 32'(opending), 1);
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        chk("co_autor_new", 32'(oautor), 32'h0002);
        chk("co_pend_clr", 32'(opending), 0);

        // reset in the middle of a music ack
        imus_req = 1'b1; imus_autor = 16'h5555;
        tick();
        chk("rst_ack_before", 32'(omus_ack), 1);
        imus_req = 1'b0; ireset = 1'b1;
        tick();
        ireset = 1'b0;
        chk_all_zero("rst_mid");
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        chk("rst_frame_autor", 32'(oautor), 0);
        chk("rst_frame_pend", 32'(opending), 0);

        // page rotation over seven frames
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            iframe_start = 1'b1;
            tick();
            iframe_start = 1'b0;
            tick();
`ifdef PAGE_ROTATE_EN
            chk($sformatf("page_%0d", i), 32'(opage), (i >= 3 && i < 6) ? 1 : 0);
`else
            chk($sformatf("page_%0d", i), 32'(opage), 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
